// File: rtl/sd_img_responder_if.sv
// SD image responder bus: controller sector requests/buffer
// port plus the byte-wide image memory port.
interface sd_img_responder_if;
  logic [31:0] sd_lba [2];
  logic [1:0]  sd_rd;
  logic [1:0]  sd_wr;
  logic [1:0]  sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [7:0]  sd_buff_din [2];
  logic        sd_buff_wr;
  logic [1:0]  mount_req;
  logic [1:0]  readonly_cfg;
  logic [1:0]  img_mounted;
  logic        img_readonly;
  logic [19:0] img_size;
  logic [19:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    output mount_req, readonly_cfg,
    output mem_rdata, mem_ack,
    input  sd_ack, sd_buff_addr, sd_buff_dout,
    input  sd_buff_wr, img_mounted, img_readonly,
    input  img_size, mem_addr, mem_req, mem_we,
    input  mem_wdata
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  mount_req, readonly_cfg,
    input  mem_rdata, mem_ack,
    output sd_ack, sd_buff_addr, sd_buff_dout,
    output sd_buff_wr, img_mounted, img_readonly,
    output img_size, mem_addr, mem_req, mem_we,
    output mem_wdata
  );
endinterface

// File: rtl/sd_img_responder.sv
// Two-drive SD sector responder moving 512-byte sectors
// between the controller buffer and a byte-wide image store.
module sd_img_responder #(
  parameter int unsigned IMG_BLOCKS = 2048,
  parameter int unsigned ACK_DELAY  = 4
) (
  input logic               CLK,
  input logic               RESET,
  sd_img_responder_if.slave bus
);
  localparam logic [63:0] SIZE_B =
    64'(IMG_BLOCKS) * 64'd512;
  localparam logic [19:0] IMG_SIZE =
    (SIZE_B > 64'h000F_FFFF) ? 20'hFFFFF : SIZE_B[19:0];
  localparam logic [7:0] ACK_LAST = 8'(ACK_DELAY - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_MOUNT,
    S_ACKWAIT,
    S_RD_REQ,
    S_RD_PUT,
    S_WR_ADDR,
    S_WR_CAP,
    S_WR_MEM,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        drv_q, drv_d;
  logic        wr_q, wr_d;
  logic [10:0] lba_q, lba_d;
  logic        inr_q, inr_d;
  logic        wpa_q, wpa_d;
  logic [8:0]  off_q, off_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  pend_q, pend_clr;
  logic [1:0]  wp_q, wp_d;
  logic        ro_q, ro_d;
  logic [19:0] size_q, size_d;

  logic        acc, acc_drv, acc_wr;
  logic        wstep;
  logic        last;
  logic        mdrv;
  logic [1:0]  drv_oh;
  logic        xfer;

  assign last   = (off_q == 9'h1FF);
  assign mdrv   = ~pend_q[0];
  assign drv_oh = drv_q ? 2'b10 : 2'b01;
  assign xfer   = (state_q == S_ACKWAIT) ||
                  (state_q == S_RD_REQ)  ||
                  (state_q == S_RD_PUT)  ||
                  (state_q == S_WR_ADDR) ||
                  (state_q == S_WR_CAP)  ||
                  (state_q == S_WR_MEM);

  assign bus.sd_ack       = xfer ? drv_oh : 2'b00;
  assign bus.sd_buff_addr = off_q;
  assign bus.sd_buff_dout = data_q;
  assign bus.sd_buff_wr   = (state_q == S_RD_PUT);
  assign bus.img_mounted  =
    ((state_q == S_MOUNT) && (cnt_q != 8'd0)) ?
    drv_oh : 2'b00;
  assign bus.img_readonly = ro_q;
  assign bus.img_size     = size_q;
  assign bus.mem_addr     = {lba_q, off_q};
  assign bus.mem_req      =
    ((state_q == S_RD_PUT) ? 1'b0 :
     ((state_q == S_RD_REQ) && inr_q)) ||
    (state_q == S_WR_MEM);
  assign bus.mem_we       = (state_q == S_WR_MEM);
  assign bus.mem_wdata    = data_q;

  // Fixed request priority: rd0, wr0, rd1, wr1.
  always_comb begin
    acc     = 1'b1;
    acc_drv = 1'b0;
    acc_wr  = 1'b0;
    if (bus.sd_rd[0]) begin
      acc_wr = 1'b0;
    end else if (bus.sd_wr[0]) begin
      acc_wr = 1'b1;
    end else if (bus.sd_rd[1]) begin
      acc_drv = 1'b1;
    end else if (bus.sd_wr[1]) begin
      acc_drv = 1'b1;
      acc_wr  = 1'b1;
    end else begin
      acc = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    drv_d    = drv_q;
    wr_d     = wr_q;
    lba_d    = lba_q;
    inr_d    = inr_q;
    wpa_d    = wpa_q;
    off_d    = off_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    wp_d     = wp_q;
    ro_d     = ro_q;
    size_d   = size_q;
    pend_clr = 2'b00;
    wstep    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (|pend_q) begin
          state_d     = S_MOUNT;
          drv_d       = mdrv;
          ro_d        = bus.readonly_cfg[mdrv];
          wp_d[mdrv]  = bus.readonly_cfg[mdrv];
          size_d      = IMG_SIZE;
        end else if (acc) begin
          drv_d = acc_drv;
          wr_d  = acc_wr;
          lba_d = bus.sd_lba[acc_drv][10:0];
          inr_d = bus.sd_lba[acc_drv] < IMG_BLOCKS;
          wpa_d = wp_q[acc_drv];
          off_d = 9'd0;
          if (ACK_DELAY == 0)
            state_d = acc_wr ? S_WR_ADDR : S_RD_REQ;
          else
            state_d = S_ACKWAIT;
        end
      end
      S_MOUNT: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd2) begin
          pend_clr = drv_oh;
          state_d  = S_IDLE;
        end
      end
      S_ACKWAIT: begin
        if (cnt_q == ACK_LAST)
          state_d = wr_q ? S_WR_ADDR : S_RD_REQ;
        else
          cnt_d = cnt_q + 8'd1;
      end
      S_RD_REQ: begin
        if (!inr_q) begin
          data_d  = 8'h00;
          state_d = S_RD_PUT;
        end else if (bus.mem_ack) begin
          data_d  = bus.mem_rdata;
          state_d = S_RD_PUT;
        end
      end
      S_RD_PUT: begin
        if (last) begin
          state_d = S_DONE;
        end else begin
          off_d   = off_q + 9'd1;
          state_d = S_RD_REQ;
        end
      end
      S_WR_ADDR: state_d = S_WR_CAP;
      S_WR_CAP: begin
        data_d = bus.sd_buff_din[drv_q];
        if (inr_q && !wpa_q)
          state_d = S_WR_MEM;
        else
          wstep = 1'b1;
      end
      S_WR_MEM: wstep = bus.mem_ack;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (wstep) begin
      if (last) begin
        state_d = S_DONE;
      end else begin
        off_d   = off_q + 9'd1;
        state_d = S_WR_ADDR;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      drv_q   <= 1'b0;
      wr_q    <= 1'b0;
      lba_q   <= '0;
      inr_q   <= 1'b0;
      wpa_q   <= 1'b0;
      off_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      wp_q    <= '0;
      ro_q    <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      drv_q   <= drv_d;
      wr_q    <= wr_d;
      lba_q   <= lba_d;
      inr_q   <= inr_d;
      wpa_q   <= wpa_d;
      off_q   <= off_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      // a new pulse wins over the clear of the same drive
      pend_q  <= (pend_q & ~pend_clr) | bus.mount_req;
      wp_q    <= wp_d;
      ro_q    <= ro_d;
      size_q  <= size_d;
    end
  end
endmodule

// File: tb/tb_sd_img_responder.sv
// Directed bench for sd_img_responder: mount, read, write,
// write-protect, out-of-range, contention and reset cases.
module tb_sd_img_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_img_responder_if bus ();

  sd_img_responder #(
    .IMG_BLOCKS(2048),
    .ACK_DELAY (4)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [1048576];
  int mem_lat = 1;
  int wcnt = 0;
  int wr_cnt = 0;

  always @(posedge clk) begin
    bus.mem_ack <= 1'b0;
    if (bus.mem_req && !bus.mem_ack) begin
      if (wcnt >= mem_lat - 1) begin
        bus.mem_ack <= 1'b1;
        wcnt <= 0;
        if (bus.mem_we) begin
          mem[bus.mem_addr] <= bus.mem_wdata;
          wr_cnt <= wr_cnt + 1;
        end else begin
          bus.mem_rdata <= mem[bus.mem_addr];
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    bus.sd_buff_din[0] <= 8'h5A ^ bus.sd_buff_addr[7:0];
    bus.sd_buff_din[1] <= 8'hA5 ^ bus.sd_buff_addr[7:0];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    bit         rise_ok;
    bit         tmo;
    int         acks;
    int         nwr;
    int         first;
    int         gap;
    int         bad;
    int         nreq;
    int         nwe;
    int         oth;
    logic [7:0] d0;
    logic [7:0] dl;
  } res_t;

  task automatic xfer(input int drv, input bit wr,
                      input logic [31:0] lba,
                      input int lat, output res_t r);
    logic [1:0]  oh;
    logic [31:0] s;
    logic [7:0]  e;
    bit          inr;
    int          t;
    int          lastt;
    oh  = (drv == 1) ? 2'b10 : 2'b01;
    inr = lba < 32'd2048;
    r   = '{default: 0};
    r.tmo = 1'b1;
    lastt = 0;
    mem_lat = lat;
    @(negedge clk);
    bus.sd_lba[drv] = lba;
    if (wr) bus.sd_wr[drv] = 1'b1;
    else    bus.sd_rd[drv] = 1'b1;
    @(negedge clk);
    r.rise_ok = (bus.sd_ack == oh);
    bus.sd_rd = 2'b00;
    bus.sd_wr = 2'b00;
    bus.sd_lba[drv] = 32'h0000_0123;
    t = 0;
    for (int c = 0; c < 6000; c++) begin
      if (bus.sd_ack == 2'b00) begin
        r.tmo = 1'b0;
        r.gap = t - lastt;
        break;
      end
      r.acks++;
      if (bus.sd_ack != oh) r.oth++;
      if (bus.sd_buff_wr) begin
        if (r.nwr == 0) r.first = t;
        lastt = t;
        s = lba + 32'(r.nwr);
        e = inr ? s[7:0] : 8'h00;
        if (r.nwr == 0) r.d0 = bus.sd_buff_dout;
        r.dl = bus.sd_buff_dout;
        if (bus.sd_buff_addr != 9'(r.nwr) ||
            bus.sd_buff_dout != e)
          r.bad++;
        r.nwr++;
      end
      if (bus.mem_req) r.nreq++;
      if (bus.mem_req && bus.mem_we) r.nwe++;
      @(negedge clk);
      t++;
    end
  endtask

  task automatic do_mount(input int drv, input bit ro,
                          output int hi,
                          output logic [19:0] sz,
                          output logic rob,
                          output logic [1:0] val,
                          output bit tmo);
    logic [1:0]  oh;
    logic [19:0] psz;
    logic        pro;
    oh  = (drv == 1) ? 2'b10 : 2'b01;
    hi  = 0;
    tmo = 1'b1;
    sz  = '0;
    rob = 1'b0;
    val = '0;
    @(negedge clk);
    bus.readonly_cfg = ro ? oh : 2'b00;
    bus.mount_req = oh;
    @(negedge clk);
    bus.mount_req = 2'b00;
    psz = bus.img_size;
    pro = bus.img_readonly;
    for (int c = 0; c < 20; c++) begin
      if (bus.img_mounted != 2'b00) begin
        if (hi == 0) begin
          sz  = psz;
          rob = pro;
          val = bus.img_mounted;
        end
        hi++;
      end else if (hi != 0) begin
        tmo = 1'b0;
        break;
      end
      psz = bus.img_size;
      pro = bus.img_readonly;
      @(negedge clk);
    end
  endtask

  typedef struct {
    int         drv;
    int         lat;
    logic [31:0] lba;
    logic [7:0] b0;
    logic [7:0] b511;
    int         first;
    int         acks;
  } rv_t;

  function automatic bit outs_zero();
    return ~|{bus.sd_ack, bus.sd_buff_addr,
              bus.sd_buff_dout, bus.sd_buff_wr,
              bus.img_mounted, bus.img_readonly,
              bus.img_size, bus.mem_addr, bus.mem_req,
              bus.mem_we, bus.mem_wdata};
  endfunction

  initial begin
    rv_t         rv [5];
    res_t        r;
    int          hi;
    logic [19:0] sz;
    logic        rob;
    logic [1:0]  val;
    bit          tmo;
    int          wbase;
    int          mm;
    logic [31:0] s;

    rv[0] = '{0, 1, 32'd5,    8'h05, 8'h04, 6, 1540};
    rv[1] = '{1, 2, 32'd300,  8'h2C, 8'h2B, 7, 2052};
    rv[2] = '{0, 1, 32'd4096, 8'h00, 8'h00, 5, 1028};
    rv[3] = '{1, 1, 32'd2047, 8'hFF, 8'hFE, 6, 1540};
    rv[4] = '{0, 3, 32'd2048, 8'h00, 8'h00, 5, 1028};

    for (int i = 0; i < 1048576; i++) begin
      s = 32'(i & 511) + 32'(i >> 9);
      mem[i] = s[7:0];
    end
    bus.sd_lba[0]    = '0;
    bus.sd_lba[1]    = '0;
    bus.sd_rd        = '0;
    bus.sd_wr        = '0;
    bus.mount_req    = '0;
    bus.readonly_cfg = '0;
    bus.mem_ack      = 1'b0;
    bus.mem_rdata    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs_zero", 32'(outs_zero()), 1);

    do_mount(0, 1'b0, hi, sz, rob, val, tmo);
    chk("mnt0_tmo", 32'(tmo), 0);
    chk("mnt0_high_cycles", hi, 2);
    chk("mnt0_size_before", 32'(sz), 32'hFFFFF);
    chk("mnt0_ro_before", 32'(rob), 0);
    chk("mnt0_onehot", 32'(val), 32'h1);

    for (int i = 0; i < 5; i++) begin
      xfer(rv[i].drv, 1'b0, rv[i].lba, rv[i].lat, r);
      chk($sformatf("rd%0d_ack_rise", i), 32'(r.rise_ok), 1);
      chk($sformatf("rd%0d_tmo", i), 32'(r.tmo), 0);
      chk($sformatf("rd%0d_strobes", i), r.nwr, 512);
      chk($sformatf("rd%0d_bad", i), r.bad, 0);
      chk($sformatf("rd%0d_b0", i), 32'(r.d0), 32'(rv[i].b0));
      chk($sformatf("rd%0d_b511", i), 32'(r.dl),
          32'(rv[i].b511));
      chk($sformatf("rd%0d_first", i), r.first, rv[i].first);
      chk($sformatf("rd%0d_acks", i), r.acks, rv[i].acks);
      chk($sformatf("rd%0d_ack_gap", i), r.gap, 1);
      chk($sformatf("rd%0d_other", i), r.oth, 0);
      chk($sformatf("rd%0d_nwe", i), r.nwe, 0);
      chk($sformatf("rd%0d_nreq", i), r.nreq,
          (rv[i].lba < 2048) ? 512 * (rv[i].lat + 1) : 0);
      repeat (2) @(negedge clk);
    end

    wbase = wr_cnt;
    xfer(1, 1'b1, 32'd7, 1, r);
    chk("wr_ack_rise", 32'(r.rise_ok), 1);
    chk("wr_tmo", 32'(r.tmo), 0);
    chk("wr_buff_wr", r.nwr, 0);
    chk("wr_mem_writes", wr_cnt - wbase, 512);
    mm = 0;
    for (int i = 0; i < 512; i++) begin
      s = 32'h0000_00A5 ^ 32'(i);
      if (mem[32'h0E00 + i] != s[7:0]) mm++;
    end
    chk("wr_mem_content", mm, 0);
    repeat (2) @(negedge clk);

    do_mount(0, 1'b1, hi, sz, rob, val, tmo);
    chk("mnt_wp_tmo", 32'(tmo), 0);
    chk("mnt_wp_high_cycles", hi, 2);
    chk("mnt_wp_ro_before", 32'(rob), 1);
    wbase = wr_cnt;
    xfer(0, 1'b1, 32'd3, 1, r);
    chk("wp_ack_rise", 32'(r.rise_ok), 1);
    chk("wp_tmo", 32'(r.tmo), 0);
    chk("wp_mem_we", r.nwe, 0);
    chk("wp_mem_writes", wr_cnt - wbase, 0);
    mm = 0;
    for (int i = 0; i < 512; i++) begin
      s = 32'(i) + 32'd3;
      if (mem[32'h0600 + i] != s[7:0]) mm++;
    end
    chk("wp_mem_untouched", mm, 0);
    repeat (2) @(negedge clk);

    begin
      int         ev [3];
      int         nev;
      int         n0;
      int         n1;
      int         both;
      int         bad;
      bit         done;
      logic [1:0] pack;
      logic       pm;
      logic [7:0] e;
      ev = '{0, 0, 0};
      nev = 0; n0 = 0; n1 = 0; both = 0; bad = 0;
      done = 1'b0; pack = 2'b00; pm = 1'b0;
      mem_lat = 1;
      @(negedge clk);
      bus.sd_lba[0] = 32'd5;
      bus.sd_lba[1] = 32'd9;
      bus.sd_rd = 2'b11;
      for (int c = 0; c < 8000; c++) begin
        if (bus.sd_ack[0]) bus.sd_rd[0] = 1'b0;
        if (bus.sd_ack[1]) bus.sd_rd[1] = 1'b0;
        bus.mount_req = (c == 100) ? 2'b10 : 2'b00;
        if (bus.sd_ack != 2'b00 && pack == 2'b00 && nev < 3) begin
          ev[nev] = bus.sd_ack[1] ? 2 : 1;
          nev++;
        end
        if (bus.img_mounted[1] && !pm && nev < 3) begin
          ev[nev] = 3;
          nev++;
        end
        if (bus.sd_ack == 2'b11) both++;
        if (bus.sd_buff_wr) begin
          if (bus.sd_ack[1]) begin
            s = 32'(n1) + 32'd9;
            n1++;
          end else begin
            s = 32'(n0) + 32'd5;
            n0++;
          end
          e = s[7:0];
          if (bus.sd_buff_dout != e) bad++;
        end
        if (pack == 2'b10 && bus.sd_ack == 2'b00) begin
          done = 1'b1;
          break;
        end
        pack = bus.sd_ack;
        pm = bus.img_mounted[1];
        @(negedge clk);
      end
      bus.mount_req = 2'b00;
      chk("ct_done", 32'(done), 1);
      chk("ct_ev0_drive0", ev[0], 1);
      chk("ct_ev1_mount1", ev[1], 3);
      chk("ct_ev2_drive1", ev[2], 2);
      chk("ct_n0", n0, 512);
      chk("ct_n1", n1, 512);
      chk("ct_both_ack", both, 0);
      chk("ct_data", bad, 0);
    end
    repeat (2) @(negedge clk);

    begin
      bit hit;
      hit = 1'b0;
      mem_lat = 1;
      @(negedge clk);
      bus.sd_lba[0] = 32'd5;
      bus.sd_rd[0] = 1'b1;
      @(negedge clk);
      bus.sd_rd[0] = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        if (bus.sd_buff_wr && bus.sd_buff_addr == 9'd200) begin
          hit = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("rst_reach200", 32'(hit), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_outs_zero", 32'(outs_zero()), 1);
      chk("rst_ack", 32'(bus.sd_ack), 0);
      chk("rst_mem_req", 32'(bus.mem_req), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_idle_ack", 32'(bus.sd_ack), 0);
    end

    xfer(0, 1'b0, 32'd5, 1, r);
    chk("post_rst_ack_rise", 32'(r.rise_ok), 1);
    chk("post_rst_tmo", 32'(r.tmo), 0);
    chk("post_rst_strobes", r.nwr, 512);
    chk("post_rst_bad", r.bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
